// File: rtl/ped_walk_sequencer_pkg.sv
// Shared definitions for the pedestrian walk sequencer: state encoding, FLASH
// length and tick-counter width, used by both the RTL and its bench.
package ped_walk_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_CAR_GO     = 3'd0,
    ST_CAR_YELLOW = 3'd1,
    ST_ALL_RED    = 3'd2,
    ST_WALK       = 3'd3,
    ST_FLASH      = 3'd4
  } state_t;

  localparam int FLASH_T = 50;
  localparam int TCNT_W  = 7;

  // Terminal tcnt value for a dwell of the given number of ticks.
  function automatic logic [TCNT_W-1:0] last_tick(input int dwell);
    return TCNT_W'(dwell - 1);
  endfunction

endpackage

// File: rtl/ped_walk_sequencer_countdown_decode.sv
// FLASH-phase decode: seconds-remaining digit (4..0) and the 0.5 s on / 0.5 s off
// blink phase, both derived from the tenth-second counter.
module ped_countdown_decode (
  input  logic [6:0] tcnt,
  output logic [3:0] count_bcd,
  output logic       blink_on
);

  logic [6:0] w_units;

  always_comb begin
    count_bcd = 4'd0;
    if      (tcnt < 7'd10) count_bcd = 4'd4;
    else if (tcnt < 7'd20) count_bcd = 4'd3;
    else if (tcnt < 7'd30) count_bcd = 4'd2;
    else if (tcnt < 7'd40) count_bcd = 4'd1;
    w_units  = tcnt % 7'd10;
    blink_on = (w_units < 7'd5);
  end

endmodule

// File: rtl/ped_walk_sequencer.sv
// Pedestrian crossing sequencer: vehicle green/yellow/all-red, solid WALK, then
// a 5 s flashing DONT_WALK countdown; all outputs are Moore-decoded from registers.
module ped_walk_sequencer
  import ped_walk_sequencer_pkg::*;
#(
  parameter int MIN_GREEN = 100,
  parameter int YELLOW_T  = 30,
  parameter int ALLRED_T  = 10,
  parameter int WALK_T    = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_10hz,
  input  logic       ped_req,
  output logic       car_green,
  output logic       car_yellow,
  output logic       car_red,
  output logic       walk,
  output logic       dont_walk,
  output logic [3:0] count_bcd,
  output logic       count_valid,
  output logic       ped_ack,
  output state_t     o_dbg_state,
  output logic [6:0] o_dbg_tcnt,
  output logic       o_dbg_req_pending
);

  state_t     r_state, w_state_nxt;
  logic [6:0] r_tcnt, w_tcnt_nxt;
  logic       r_req_pending, w_req_pending_nxt;
  logic       r_ped_ack, w_ped_ack_nxt;
  logic [6:0] w_dwell_last;
  logic       w_at_last;
  logic       w_fire;
  logic [3:0] w_bcd;
  logic       w_blink_on;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_CAR_GO;
      r_tcnt        <= 7'd0;
      r_req_pending <= 1'b0;
      r_ped_ack     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tcnt        <= w_tcnt_nxt;
      r_req_pending <= w_req_pending_nxt;
      r_ped_ack     <= w_ped_ack_nxt;
    end
  end

  always_comb begin
    w_dwell_last = last_tick(MIN_GREEN);
    case (r_state)
      ST_CAR_GO:     w_dwell_last = last_tick(MIN_GREEN);
      ST_CAR_YELLOW: w_dwell_last = last_tick(YELLOW_T);
      ST_ALL_RED:    w_dwell_last = last_tick(ALLRED_T);
      ST_WALK:       w_dwell_last = last_tick(WALK_T);
      ST_FLASH:      w_dwell_last = last_tick(FLASH_T);
      default:       w_dwell_last = last_tick(MIN_GREEN);
    endcase
    w_at_last = (r_tcnt == w_dwell_last);
    // CAR_GO is the only state that waits for a request once its dwell is met.
    w_fire = tick_10hz && w_at_last && ((r_state != ST_CAR_GO) || r_req_pending);

    w_state_nxt = r_state;
    if (w_fire) begin
      case (r_state)
        ST_CAR_GO:     w_state_nxt = ST_CAR_YELLOW;
        ST_CAR_YELLOW: w_state_nxt = ST_ALL_RED;
        ST_ALL_RED:    w_state_nxt = ST_WALK;
        ST_WALK:       w_state_nxt = ST_FLASH;
        ST_FLASH:      w_state_nxt = ST_CAR_GO;
        default:       w_state_nxt = ST_CAR_GO;
      endcase
    end

    // Holding at the terminal value only ever happens in CAR_GO (saturation).
    w_tcnt_nxt = r_tcnt;
    if (w_fire)                      w_tcnt_nxt = 7'd0;
    else if (tick_10hz && !w_at_last) w_tcnt_nxt = r_tcnt + 7'd1;

    w_ped_ack_nxt     = w_fire && (r_state == ST_ALL_RED);
    w_req_pending_nxt = r_req_pending;
    if (w_ped_ack_nxt) w_req_pending_nxt = 1'b0;
    else if (ped_req)  w_req_pending_nxt = 1'b1;
  end

  ped_countdown_decode u_decode (
    .tcnt      (r_tcnt),
    .count_bcd (w_bcd),
    .blink_on  (w_blink_on)
  );

  always_comb begin
    car_green   = (r_state == ST_CAR_GO);
    car_yellow  = (r_state == ST_CAR_YELLOW);
    car_red     = !(car_green || car_yellow);
    walk        = (r_state == ST_WALK);
    count_valid = (r_state == ST_FLASH);
    count_bcd   = count_valid ? w_bcd : 4'd0;
    case (r_state)
      ST_WALK:  dont_walk = 1'b0;
      ST_FLASH: dont_walk = w_blink_on;
      default:  dont_walk = 1'b1;
    endcase
  end

  assign ped_ack           = r_ped_ack;
  assign o_dbg_state       = r_state;
  assign o_dbg_tcnt        = r_tcnt;
  assign o_dbg_req_pending = r_req_pending;

endmodule

// File: tb/tb_ped_walk_sequencer.sv
// Bench for ped_walk_sequencer: a default-timing instance and an all-1-tick
// instance share stimulus and are checked every clock against a phase/tick model.
module tb_ped_walk_sequencer;
  import ped_walk_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_10hz = 1'b0;
  logic       ped_req = 1'b0;
  logic       cg[2], cy[2], cr[2], wk[2], dw[2], cv[2], ack[2], pend[2];
  logic [3:0] bcd[2];
  logic [6:0] tc[2];
  state_t     st[2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ped_walk_sequencer u_dut_a (
    .clk(clk), .reset(reset), .tick_10hz(tick_10hz), .ped_req(ped_req),
    .car_green(cg[0]), .car_yellow(cy[0]), .car_red(cr[0]), .walk(wk[0]),
    .dont_walk(dw[0]), .count_bcd(bcd[0]), .count_valid(cv[0]), .ped_ack(ack[0]),
    .o_dbg_state(st[0]), .o_dbg_tcnt(tc[0]), .o_dbg_req_pending(pend[0])
  );

  ped_walk_sequencer #(.MIN_GREEN(1), .YELLOW_T(1), .ALLRED_T(1), .WALK_T(1)) u_dut_b (
    .clk(clk), .reset(reset), .tick_10hz(tick_10hz), .ped_req(ped_req),
    .car_green(cg[1]), .car_yellow(cy[1]), .car_red(cr[1]), .walk(wk[1]),
    .dont_walk(dw[1]), .count_bcd(bcd[1]), .count_valid(cv[1]), .ped_ack(ack[1]),
    .o_dbg_state(st[1]), .o_dbg_tcnt(tc[1]), .o_dbg_req_pending(pend[1])
  );

  // Reference model: phase index into a dwell table plus ticks spent in phase.
  state_t ph2st[5] = '{ST_CAR_GO, ST_CAR_YELLOW, ST_ALL_RED, ST_WALK, ST_FLASH};
  int     dwell[2][5] = '{'{100, 30, 10, 50, FLASH_T}, '{1, 1, 1, 1, FLASH_T}};
  int     m_ph[2], m_tk[2];
  bit     m_pend[2], m_ack[2];

  task automatic model_step(input int k, input bit rst, input bit tk, input bit rq);
    bit fire;
    if (rst) begin
      m_ph[k] = 0; m_tk[k] = 0; m_pend[k] = 0; m_ack[k] = 0;
    end else begin
      fire = tk && (m_tk[k] == dwell[k][m_ph[k]] - 1) && (m_ph[k] != 0 || m_pend[k]);
      m_ack[k] = fire && (m_ph[k] == 2);
      if (m_ack[k]) m_pend[k] = 0;
      else if (rq)  m_pend[k] = 1;
      if (fire) begin
        m_ph[k] = (m_ph[k] + 1) % 5;
        m_tk[k] = 0;
      end else if (tk && m_tk[k] < dwell[k][m_ph[k]] - 1) begin
        m_tk[k] = m_tk[k] + 1;
      end
    end
  endtask

  function automatic logic [20:0] exp_vec(input int k);
    int         ph;
    int         tk;
    bit         fl;
    logic [3:0] eb;
    ph = m_ph[k];
    tk = m_tk[k];
    fl = (ph == 4);
    eb = fl ? 4'(4 - tk / 10) : 4'd0;
    return {ph == 0, ph == 1, ph >= 2, ph == 3, (ph < 3) || (fl && (tk % 10) < 5),
            eb, fl, m_ack[k], ph2st[ph], m_pend[k], 7'(tk)};
  endfunction

  function automatic logic [20:0] got_vec(input int k);
    return {cg[k], cy[k], cr[k], wk[k], dw[k], bcd[k], cv[k], ack[k], st[k], pend[k], tc[k]};
  endfunction

  task automatic check_model(input int k);
    logic [20:0] g;
    logic [20:0] e;
    g = got_vec(k);
    e = exp_vec(k);
    n_vec++;
    if (g !== e) begin
      n_err++;
      $display("FAIL model dut%0d t=%0t got=%h exp=%h", k, $time, g, e);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic int st_idx(input state_t s);
    int r;
    r = -1;
    for (int i = 0; i < 5; i++) if (ph2st[i] == s) r = i;
    return r;
  endfunction

  // One clock: drive inputs away from the edge, step the model, sample at +1.
  task automatic cycle(input bit rst, input bit tk, input bit rq);
    reset = rst; tick_10hz = tk; ped_req = rq;
    @(posedge clk);
    model_step(0, rst, tk, rq);
    model_step(1, rst, tk, rq);
    #1;
    check_model(0);
    check_model(1);
  endtask

  // Tick-numbered run of dut A with transition scoreboard.
  int rq_ticks[$];
  int exp_q[$];
  int exp_t_q[$];

  task automatic run_seq(input string name, input int n, input int flash_at);
    int got_s[$];
    int got_t[$];
    int prev;
    int cur;
    int fl;
    bit rq;
    cycle(1, 0, 0);
    prev = st_idx(st[0]);
    for (int t = 1; t <= n; t++) begin
      rq = 0;
      foreach (rq_ticks[i]) if (rq_ticks[i] == t) rq = 1;
      cycle(0, 1, rq);
      cur = st_idx(st[0]);
      if (cur != prev) begin
        got_s.push_back(cur);
        got_t.push_back(t);
        prev = cur;
      end
      if (flash_at >= 0 && t >= flash_at && t < flash_at + FLASH_T) begin
        fl = t - flash_at;
        check_int({name, " count_bcd"}, int'(bcd[0]), 4 - fl / 10);
        check_int({name, " flash_dont_walk"}, int'(dw[0]), ((fl % 10) < 5) ? 1 : 0);
        check_int({name, " count_valid"}, int'(cv[0]), 1);
      end
      cycle(0, 0, 0);
    end
    check_int({name, " n_transitions"}, got_s.size(), exp_q.size());
    foreach (exp_q[i]) begin
      check_int({name, " entry_state"}, (i < got_s.size()) ? got_s[i] : -1, exp_q[i]);
      check_int({name, " entry_tick"}, (i < got_t.size()) ? got_t[i] : -1, exp_t_q[i]);
    end
  endtask

  typedef struct {
    bit     rst;
    bit     tk;
    bit     rq;
    state_t st;
    bit     ack;
    bit     walk;
    bit     dont_walk;
    bit     valid;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int n;
    // Idle: no request for 300 ticks keeps dut A in CAR_GO.
    rq_ticks = {}; exp_q = {}; exp_t_q = {};
    run_seq("idle", 300, -1);

    // Request at tick 20, a second one during FLASH.
    rq_ticks = {20, 200};
    exp_q = {1, 2, 3, 4, 0, 1};
    exp_t_q = {100, 130, 140, 190, 240, 340};
    run_seq("req20", 345, 190);

    // Request on the WALK entry edge is discarded: exactly one cycle.
    rq_ticks = {20, 140};
    exp_q = {1, 2, 3, 4, 0};
    exp_t_q = {100, 130, 140, 190, 240};
    run_seq("walk_edge_req", 600, -1);

    // Reset at FLASH tick 23, with tick and request high during reset.
    rq_ticks = {20};
    exp_q = {1, 2, 3, 4};
    exp_t_q = {100, 130, 140, 190};
    run_seq("pre_reset", 213, -1);
    check_int("mid_flash_tcnt", int'(tc[0]), 23);
    cycle(1, 1, 1);
    check_int("reset_state", st_idx(st[0]), 0);
    check_int("reset_count_valid", int'(cv[0]), 0);
    check_int("reset_req_pending", int'(pend[0]), 0);
    cycle(0, 0, 0);
    check_int("post_reset_req_pending", int'(pend[0]), 0);

    // All-1-tick instance, held request: table of expected lamps per clock.
    vecs[0]  = '{1, 0, 0, ST_CAR_GO,     0, 0, 1, 0};
    vecs[1]  = '{0, 1, 1, ST_CAR_GO,     0, 0, 1, 0};
    vecs[2]  = '{0, 1, 1, ST_CAR_YELLOW, 0, 0, 1, 0};
    vecs[3]  = '{0, 1, 1, ST_ALL_RED,    0, 0, 1, 0};
    vecs[4]  = '{0, 1, 1, ST_WALK,       1, 1, 0, 0};
    vecs[5]  = '{0, 1, 1, ST_FLASH,      0, 0, 1, 1};
    vecs[6]  = '{0, 0, 1, ST_FLASH,      0, 0, 1, 1};
    vecs[7]  = '{0, 1, 1, ST_FLASH,      0, 0, 1, 1};
    vecs[8]  = '{0, 1, 1, ST_FLASH,      0, 0, 1, 1};
    vecs[9]  = '{0, 1, 1, ST_FLASH,      0, 0, 1, 1};
    vecs[10] = '{0, 1, 1, ST_FLASH,      0, 0, 1, 1};
    vecs[11] = '{0, 1, 1, ST_FLASH,      0, 0, 0, 1};
    vecs[12] = '{0, 0, 1, ST_FLASH,      0, 0, 0, 1};
    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].tk, vecs[i].rq);
      n_vec++;
      if ({st[1], ack[1], wk[1], dw[1], cv[1]} !==
          {vecs[i].st, vecs[i].ack, vecs[i].walk, vecs[i].dont_walk, vecs[i].valid}) begin
        n_err++;
        $display("FAIL table row %0d got=%h exp=%h", i,
                 {st[1], ack[1], wk[1], dw[1], cv[1]},
                 {vecs[i].st, vecs[i].ack, vecs[i].walk, vecs[i].dont_walk, vecs[i].valid});
      end
    end
    // Five FLASH ticks already taken by the table; the rest must total 50.
    n = 5;
    for (int i = 0; i < 100 && st[1] != ST_CAR_GO; i++) begin
      cycle(0, 1, 1);
      n++;
    end
    check_int("fast_flash_ticks", n, FLASH_T);
    cycle(0, 1, 1);
    check_int("fast_yellow", st_idx(st[1]), 1);
    cycle(0, 1, 1);
    check_int("fast_all_red", st_idx(st[1]), 2);
    cycle(0, 1, 1);
    check_int("fast_walk", st_idx(st[1]), 3);
    check_int("fast_ack", int'(ack[1]), 1);
    cycle(0, 1, 1);
    check_int("fast_flash", st_idx(st[1]), 4);

    // Random traffic on both instances against the model.
    cycle(1, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
